// File: rtl/dof_ex_register.sv
// dof_ex_register: DOF/EX pipeline register with one-deep RAW hazard stall,
// bubble insertion on flush/hazard/invalid, and a saturating stall counter.
module dof_ex_register #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [31:0]      a_data_i,
    input  logic [31:0]      b_data_i,
    input  logic [31:0]      const_data_i,
    input  logic             mb_i,
    input  logic [4:0]       sa_i,
    input  logic [4:0]       sb_i,
    input  logic [4:0]       da_i,
    input  logic             rw_i,
    input  logic             mw_i,
    input  logic [4:0]       fs_i,
    input  logic [1:0]       md_i,
    input  logic [1:0]       bs_i,
    input  logic             ps_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [31:0]      ex_a_o,
    output logic [31:0]      ex_b_o,
    output logic [4:0]       ex_da_o,
    output logic             ex_rw_o,
    output logic             ex_mw_o,
    output logic [4:0]       ex_fs_o,
    output logic [1:0]       ex_md_o,
    output logic [1:0]       ex_bs_o,
    output logic             ex_ps_o,
    output logic [CNT_W-1:0] haz_cnt_o
);
    logic             ex_valid_q, ex_valid_d;
    logic [31:0]      ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [4:0]       ex_da_q, ex_da_d, ex_fs_q, ex_fs_d;
    logic             ex_rw_q, ex_rw_d, ex_mw_q, ex_mw_d, ex_ps_q, ex_ps_d;
    logic [1:0]       ex_md_q, ex_md_d, ex_bs_q, ex_bs_d;
    logic [CNT_W-1:0] haz_cnt_q, haz_cnt_d;
    logic             ex_writes, haz_a, haz_b, hazard, bubble;

    // A bubble has rw=0 and da=0, so it can never be a hazard producer.
    assign ex_writes = ex_valid_q & ex_rw_q & (ex_da_q != 5'd0);
    assign haz_a     = in_valid_i & ex_writes & (ex_da_q == sa_i);
    assign haz_b     = in_valid_i & ex_writes & (ex_da_q == sb_i) & ~mb_i;
    assign hazard    = haz_a | haz_b;
    assign stall_o   = hazard & ~flush_i;
    assign bubble    = flush_i | hazard | ~in_valid_i;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_da_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mw_d    = 1'b0;
        ex_fs_d    = '0;
        ex_md_d    = '0;
        ex_bs_d    = '0;
        ex_ps_d    = 1'b0;
        if (!bubble) begin
            ex_valid_d = 1'b1;
            ex_a_d     = a_data_i;
            ex_b_d     = mb_i ? const_data_i : b_data_i;
            ex_da_d    = da_i;
            ex_rw_d    = rw_i;
            ex_mw_d    = mw_i;
            ex_fs_d    = fs_i;
            ex_md_d    = md_i;
            ex_bs_d    = bs_i;
            ex_ps_d    = ps_i;
        end
        haz_cnt_d = (stall_o && haz_cnt_q != '1) ? haz_cnt_q + 1'b1 : haz_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_da_q    <= '0;
            ex_rw_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_fs_q    <= '0;
            ex_md_q    <= '0;
            ex_bs_q    <= '0;
            ex_ps_q    <= 1'b0;
            haz_cnt_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_da_q    <= ex_da_d;
            ex_rw_q    <= ex_rw_d;
            ex_mw_q    <= ex_mw_d;
            ex_fs_q    <= ex_fs_d;
            ex_md_q    <= ex_md_d;
            ex_bs_q    <= ex_bs_d;
            ex_ps_q    <= ex_ps_d;
            haz_cnt_q  <= haz_cnt_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign ex_a_o     = ex_a_q;
    assign ex_b_o     = ex_b_q;
    assign ex_da_o    = ex_da_q;
    assign ex_rw_o    = ex_rw_q;
    assign ex_mw_o    = ex_mw_q;
    assign ex_fs_o    = ex_fs_q;
    assign ex_md_o    = ex_md_q;
    assign ex_bs_o    = ex_bs_q;
    assign ex_ps_o    = ex_ps_q;
    assign haz_cnt_o  = haz_cnt_q;
endmodule

// File: tb/tb_dof_ex_register.sv
// tb_dof_ex_register: directed vectors with a queue-based scoreboard; counter
// width is reduced so saturation is reachable in a short run.
module tb_dof_ex_register;
    localparam int CW = 2;

    typedef struct packed {
        logic v; logic [31:0] a, b, c; logic mb; logic [4:0] sa, sb, da;
        logic rw, mw; logic [4:0] fs; logic [1:0] md, bs; logic ps, flush;
    } in_t;
    typedef struct packed {
        logic stall, v; logic [31:0] a, b; logic [4:0] da; logic rw, mw;
        logic [4:0] fs; logic [1:0] md, bs; logic ps; logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, mb = 1'b0, rw = 1'b0, mw = 1'b0, ps = 1'b0, flush = 1'b0;
    logic [31:0] a_data = '0, b_data = '0, const_data = '0;
    logic [4:0] sa = '0, sb = '0, da = '0, fs = '0;
    logic [1:0] md = '0, bs = '0;
    logic stall, ex_valid, ex_rw, ex_mw, ex_ps;
    logic [31:0] ex_a, ex_b;
    logic [4:0] ex_da, ex_fs;
    logic [1:0] ex_md, ex_bs;
    logic [CW-1:0] haz_cnt;

    int checks = 0, failures = 0;
    exp_t q[$];
    exp_t cur;
    logic pend = 1'b0;

    dof_ex_register #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .a_data_i(a_data),
        .b_data_i(b_data), .const_data_i(const_data), .mb_i(mb), .sa_i(sa), .sb_i(sb),
        .da_i(da), .rw_i(rw), .mw_i(mw), .fs_i(fs), .md_i(md), .bs_i(bs), .ps_i(ps),
        .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid), .ex_a_o(ex_a),
        .ex_b_o(ex_b), .ex_da_o(ex_da), .ex_rw_o(ex_rw), .ex_mw_o(ex_mw), .ex_fs_o(ex_fs),
        .ex_md_o(ex_md), .ex_bs_o(ex_bs), .ex_ps_o(ex_ps), .haz_cnt_o(haz_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input exp_t e);
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(e.v));
        chk({tag, " ex_a"}, ex_a, e.a);
        chk({tag, " ex_b"}, ex_b, e.b);
        chk({tag, " ex_da"}, 32'(ex_da), 32'(e.da));
        chk({tag, " ex_rw"}, 32'(ex_rw), 32'(e.rw));
        chk({tag, " ex_mw"}, 32'(ex_mw), 32'(e.mw));
        chk({tag, " ex_fs"}, 32'(ex_fs), 32'(e.fs));
        chk({tag, " ex_md"}, 32'(ex_md), 32'(e.md));
        chk({tag, " ex_bs"}, 32'(ex_bs), 32'(e.bs));
        chk({tag, " ex_ps"}, 32'(ex_ps), 32'(e.ps));
        chk({tag, " haz_cnt"}, 32'(haz_cnt), 32'(e.cnt));
    endtask

    // Drive one cycle's inputs just after the edge and queue the expectation.
    task automatic step(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = i.v; a_data = i.a; b_data = i.b; const_data = i.c; mb = i.mb;
        sa = i.sa; sb = i.sb; da = i.da; rw = i.rw; mw = i.mw; fs = i.fs;
        md = i.md; bs = i.bs; ps = i.ps; flush = i.flush;
        q.push_back(e);
    endtask

    // Monitor: stall checked mid-cycle, EX registers after the following edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("stall", 32'(stall), 32'(cur.stall));
            pend = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (pend) begin
            #2;
            chk_ex("ex", cur);
            pend = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_t h;
        #1;
        chk_ex("por", '{default: 0});
        chk("por stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        // pass-through with constant B
        step('{v:1, a:32'h11111111, b:32'h22222222, c:32'hFFFFC000, mb:1, sa:1, sb:2, da:3, rw:1, fs:5, default:0},
             '{v:1, a:32'h11111111, b:32'hFFFFC000, da:3, rw:1, fs:5, default:0});
        // SA hazard, then held inputs load
        step('{v:1, a:32'hA, b:32'hB, sa:3, da:6, rw:1, fs:2, md:1, default:0},
             '{stall:1, cnt:1, default:0});
        step('{v:1, a:32'hA, b:32'hB, sa:3, da:6, rw:1, fs:2, md:1, default:0},
             '{v:1, a:32'hA, b:32'hB, da:6, rw:1, fs:2, md:1, cnt:1, default:0});
        // producer DA=4, all control fields exercised
        step('{v:1, a:32'h40, b:32'h41, sa:1, sb:2, da:4, rw:1, mw:1, fs:7, md:2, bs:3, ps:1, default:0},
             '{v:1, a:32'h40, b:32'h41, da:4, rw:1, mw:1, fs:7, md:2, bs:3, ps:1, cnt:1, default:0});
        // SB matches but MB=1: no hazard
        step('{v:1, a:32'h70, b:32'h71, c:32'h1234, mb:1, sa:7, sb:4, da:8, fs:1, default:0},
             '{v:1, a:32'h70, b:32'h1234, da:8, fs:1, cnt:1, default:0});
        step('{v:1, a:32'h40, b:32'h41, sa:1, sb:2, da:4, rw:1, default:0},
             '{v:1, a:32'h40, b:32'h41, da:4, rw:1, cnt:1, default:0});
        // same with MB=0: B hazard
        step('{v:1, a:32'h70, b:32'h71, c:32'h1234, sa:7, sb:4, da:8, fs:1, default:0},
             '{stall:1, cnt:2, default:0});
        // producer writes R0
        step('{v:1, a:32'h80, b:32'h81, da:0, rw:1, fs:3, default:0},
             '{v:1, a:32'h80, b:32'h81, rw:1, fs:3, cnt:2, default:0});
        step('{v:1, a:32'h90, b:32'h91, da:5, default:0},
             '{v:1, a:32'h90, b:32'h91, da:5, cnt:2, default:0});
        // producer RW=0
        step('{v:1, a:32'hA0, b:32'hA1, sa:5, sb:5, da:9, rw:1, default:0},
             '{v:1, a:32'hA0, b:32'hA1, da:9, rw:1, cnt:2, default:0});
        // flush overrides hazard
        step('{v:1, a:32'hB0, sa:9, da:1, rw:1, flush:1, default:0},
             '{cnt:2, default:0});
        step('{v:1, a:32'h1, b:32'h2, da:10, rw:1, fs:4, default:0},
             '{v:1, a:32'h1, b:32'h2, da:10, rw:1, fs:4, cnt:2, default:0});
        // invalid DOF: no hazard, bubble
        step('{v:0, a:32'hC0, sa:10, da:2, rw:1, default:0},
             '{cnt:2, default:0});
        step('{v:1, a:32'h33, b:32'h44, da:3, rw:1, default:0},
             '{v:1, a:32'h33, b:32'h44, da:3, rw:1, cnt:2, default:0});
        // async reset in the middle of a stall
        @(posedge clk); #3;
        in_valid = 1'b1; sa = 5'd3; flush = 1'b0;
        #1 chk("pre-reset stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_ex("reset", '{default: 0});
        chk("reset stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        // saturation: alternating hazard/load with held inputs
        h = '{v:1, a:32'h5, sa:3, da:3, rw:1, default:0};
        step('{v:1, a:32'h5, sa:1, da:3, rw:1, default:0}, '{v:1, a:32'h5, da:3, rw:1, default:0});
        step(h, '{stall:1, cnt:1, default:0});
        step(h, '{v:1, a:32'h5, da:3, rw:1, cnt:1, default:0});
        step(h, '{stall:1, cnt:2, default:0});
        step(h, '{v:1, a:32'h5, da:3, rw:1, cnt:2, default:0});
        step(h, '{stall:1, cnt:3, default:0});
        step(h, '{v:1, a:32'h5, da:3, rw:1, cnt:3, default:0});
        step(h, '{stall:1, cnt:3, default:0});
        step('{default:0}, '{cnt:3, default:0});
        repeat (3) @(posedge clk);
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dof_ex_register.md
# dof_ex_register

Pipeline register between the Decode/Operand-Fetch (DOF) stage and the Execute (EX) stage of the 32-bit RISC core. It captures the A operand, the B operand and the decoded control fields. The B operand is either register data or the extended immediate produced by the constant unit. The block also detects read-after-write hazards against the instruction currently in EX, stalls DOF, and inserts bubbles. It counts hazard stalls for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the hazard-stall counter.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  DOF holds a valid instruction.
- A_DATA  in  32  register-file port A read data.
- B_DATA  in  32  register-file port B read data.
- CONST_DATA  in  32  zero/sign-extended immediate from the constant unit.
- MB  in  1  1 = B operand is CONST_DATA; 0 = B_DATA.
- SA, SB  in  5  source register addresses.
- DA  in  5  destination register address.
- RW  in  1  register write enable.
- MW  in  1  memory write enable.
- FS  in  5  function-unit select.
- MD  in  2  write-back mux select.
- BS  in  2  branch select.
- PS  in  1  branch polarity.
- FLUSH  in  1  branch taken in EX; kill the DOF instruction.
- STALL  out  1  combinational; hold the PC and the IF/DOF register this cycle.
- EX_VALID  out  1  EX holds a valid instruction.
- EX_A, EX_B  out  32  registered operands.
- EX_DA  out  5; EX_RW, EX_MW  out  1; EX_FS  out  5; EX_MD, EX_BS  out  2; EX_PS  out  1  registered control.
- HAZ_CNT  out  CNT_W  saturating count of hazard stalls.

## Operation
- haz_a = IN_VALID & EX_VALID & EX_RW & (EX_DA != 0) & (EX_DA == SA).
- haz_b = the same check against SB, additionally qualified by !MB. A constant B operand never causes a hazard.
- hazard = haz_a | haz_b.
- STALL = hazard & !FLUSH.
- Each cycle, the register load is chosen by priority:
  1. FLUSH: load a bubble.
  2. else hazard: load a bubble and increment HAZ_CNT.
  3. else !IN_VALID: load a bubble.
  4. else load normally.
- Normal load:
  - EX_VALID=1.
  - EX_A=A_DATA.
  - EX_B = MB ? CONST_DATA : B_DATA.
  - All control fields copied.
- Bubble:
  - EX_VALID=0.
  - EX_RW=0, EX_MW=0.
  - EX_DA=0, EX_FS=0, EX_MD=0, EX_BS=0, EX_PS=0.
  - EX_A=0, EX_B=0.
  - A bubble never matches the hazard check and never writes.
- HAZ_CNT increments by 1 on each hazard cycle that is not flushed. It saturates at all-ones and does not wrap.
- Only a one-deep hazard is detected. The producer sits in WB on the cycle after a stall, and the register file's write-through covers that case.
- A stall lasts exactly one cycle, because the inserted bubble clears the hazard on the next cycle.
- Register R0 (address 0) never causes a hazard.

## Timing
- Reset (RST_N low, asynchronous assert) drives the following, independent of CLK:
  - EX_VALID=0.
  - All EX_* outputs 0.
  - HAZ_CNT=0.
  - STALL then evaluates to 0, because EX_VALID=0.
- Reset release is sampled at the next rising CLK edge.
- Latency: DOF inputs appear on EX_* one cycle after the edge that samples them.
- STALL is valid in the same cycle as the inputs and EX_* registers it is computed from. It has no registered delay.
- FLUSH in the same cycle as a hazard gives STALL=0 and a bubble. HAZ_CNT does not change.
- Reset asserted mid-stall cancels the stall immediately. No partial state is retained.

## Test plan
- Reset: assert RST_N=0 mid-run with EX_VALID=1 -> all EX_* outputs, HAZ_CNT and STALL read 0 without waiting for a clock edge.
- Pass-through with constant:
  - Stimulus: IN_VALID=1, A_DATA=0x11111111, B_DATA=0x22222222, CONST_DATA=0xFFFFC000, MB=1, DA=3, RW=1, FS=5.
  - Response: next cycle EX_A=0x11111111, EX_B=0xFFFFC000, EX_DA=3, EX_RW=1, EX_FS=5, EX_VALID=1.
- SA hazard:
  - Stimulus: EX holds DA=3, RW=1; the new instruction has SA=3.
  - Response: STALL=1 that cycle and a bubble next cycle (EX_VALID=0, EX_RW=0), HAZ_CNT=1.
  - With inputs held, the following cycle has STALL=0 and the instruction loads.
- MB suppresses the B hazard:
  - Stimulus: EX DA=4, RW=1; new SB=4, SA=7, MB=1.
  - Response: STALL=0, normal load. Repeating with MB=0 gives STALL=1.
- R0 and RW=0:
  - EX DA=0, RW=1 with SA=0 -> no stall.
  - EX DA=5, RW=0 with SA=5 -> no stall.
- Flush overrides hazard: hazard condition plus FLUSH=1 -> STALL=0, next cycle EX_VALID=0, HAZ_CNT unchanged.
